// File: rtl/sram_arb_pkg.sv
// Shared types for the SLC-3 SRAM arbiter.
// Sequencer states, grant ids and the wait-counter width.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } state_t;

  typedef enum logic {
    GNT_CPU,
    GNT_LD
  } grant_t;

  localparam int WAIT_W = 4;

endpackage

// File: rtl/sram_wait_timer.sv
// Loadable down-counter with a zero flag.
// Sets the length of the SRAM ACCESS phase.
module sram_wait_timer
  import sram_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [WAIT_W-1:0] i_val,
  input  logic              i_dec,
  output logic              o_zero
);

  logic [WAIT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - WAIT_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter and strobe sequencer
// for the shared SLC-3 SRAM (CPU port and loader port).
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 16,
  parameter int WAIT_CYC = 2
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_ack,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0] sram_dq_in,
  output logic [DATA_W-1:0] sram_dq_out,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              busy
);

  localparam logic [WAIT_W-1:0] LP_LOAD =
    WAIT_W'(WAIT_CYC - 1);

  logic r_rst_meta;
  logic r_rst_sync;
  logic w_rst_n;

  state_t r_state;
  state_t w_next;
  grant_t r_gnt;
  grant_t r_last;
  grant_t w_gnt;

  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_ld_rdata;

  logic w_grant;
  logic w_load;
  logic w_dec;
  logic w_zero;
  logic w_busy;
  logic w_capture;

  // Reset asserts at once but releases on a clock edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= r_rst_meta;
    end
  end

  assign w_rst_n = r_rst_sync;

  sram_wait_timer u_timer (
    .clk    (Clk),
    .rst_n  (w_rst_n),
    .i_load (w_load),
    .i_val  (LP_LOAD),
    .i_dec  (w_dec),
    .o_zero (w_zero)
  );

  always_comb begin
    w_next  = r_state;
    w_gnt   = GNT_CPU;
    w_grant = 1'b0;
    w_load  = 1'b0;
    w_dec   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (cpu_req || ld_req) begin
          w_grant = 1'b1;
          w_next  = SETUP;
          if (cpu_req && ld_req) begin
            w_gnt = (r_last == GNT_CPU) ?
                    GNT_LD : GNT_CPU;
          end else begin
            w_gnt = cpu_req ? GNT_CPU : GNT_LD;
          end
        end
      end
      SETUP: begin
        w_load = 1'b1;
        w_next = ACCESS;
      end
      ACCESS: begin
        if (w_zero) begin
          w_next = DONE;
        end else begin
          w_dec = 1'b1;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= IDLE;
      r_gnt   <= GNT_CPU;
      r_last  <= GNT_LD;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_gnt  <= w_gnt;
        r_last <= w_gnt;
        if (w_gnt == GNT_CPU) begin
          r_we    <= cpu_we;
          r_addr  <= cpu_addr;
          r_wdata <= cpu_wdata;
        end else begin
          r_we    <= ld_we;
          r_addr  <= ld_addr;
          r_wdata <= ld_wdata;
        end
      end
    end
  end

  assign w_capture = (r_state == ACCESS) &&
                     w_zero && !r_we;

  always_ff @(posedge Clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_cpu_rdata <= '0;
      r_ld_rdata  <= '0;
    end else if (w_capture) begin
      if (r_gnt == GNT_CPU) begin
        r_cpu_rdata <= sram_dq_in;
      end else begin
        r_ld_rdata <= sram_dq_in;
      end
    end
  end

  assign w_busy      = (r_state != IDLE);
  assign busy        = w_busy;
  assign sram_ce_n   = !w_busy;
  assign sram_oe_n   = !((r_state == ACCESS) && !r_we);
  assign sram_we_n   = !((r_state == ACCESS) && r_we);
  assign sram_dq_oe  = w_busy && r_we;
  assign sram_dq_out = sram_dq_oe ? r_wdata : '0;
  assign sram_addr   = r_addr;

  assign cpu_ack   = (r_state == DONE) &&
                     (r_gnt == GNT_CPU);
  assign ld_ack    = (r_state == DONE) &&
                     (r_gnt == GNT_LD);
  assign cpu_rdata = r_cpu_rdata;
  assign ld_rdata  = r_ld_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios plus
// randomized two-port traffic against a transaction-level model.
module tb_sram_arbiter;

  localparam int AW = 20;
  localparam int DW = 16;
  localparam int WC = 2;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  logic          cpu_req, cpu_we, cpu_ack;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          ld_req, ld_we, ld_ack;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata, ld_rdata;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_dq_in, sram_dq_out;
  logic          sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, busy;

  logic          d1_cpu_req, d1_cpu_we, d1_cpu_ack;
  logic [AW-1:0] d1_cpu_addr;
  logic [DW-1:0] d1_cpu_wdata, d1_cpu_rdata;
  logic          d1_ld_req, d1_ld_we, d1_ld_ack;
  logic [AW-1:0] d1_ld_addr;
  logic [DW-1:0] d1_ld_wdata, d1_ld_rdata;
  logic [AW-1:0] d1_addr;
  logic [DW-1:0] d1_dq_in, d1_dq_out;
  logic          d1_dq_oe, d1_ce_n, d1_oe_n, d1_we_n, d1_busy;

  int n_cmp = 0;
  int n_bad = 0;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(WC)) u_dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr),
    .ld_wdata(ld_wdata), .ld_rdata(ld_rdata), .ld_ack(ld_ack),
    .sram_addr(sram_addr), .sram_dq_in(sram_dq_in),
    .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .busy(busy)
  );

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(1)) u_dut1 (
    .Clk(Clk), .Reset_n(Reset_n),
    .cpu_req(d1_cpu_req), .cpu_we(d1_cpu_we), .cpu_addr(d1_cpu_addr),
    .cpu_wdata(d1_cpu_wdata), .cpu_rdata(d1_cpu_rdata),
    .cpu_ack(d1_cpu_ack),
    .ld_req(d1_ld_req), .ld_we(d1_ld_we), .ld_addr(d1_ld_addr),
    .ld_wdata(d1_ld_wdata), .ld_rdata(d1_ld_rdata), .ld_ack(d1_ld_ack),
    .sram_addr(d1_addr), .sram_dq_in(d1_dq_in),
    .sram_dq_out(d1_dq_out), .sram_dq_oe(d1_dq_oe),
    .sram_ce_n(d1_ce_n), .sram_oe_n(d1_oe_n),
    .sram_we_n(d1_we_n), .busy(d1_busy)
  );

  function automatic logic [15:0] init_val(input logic [7:0] a);
    if (a == 8'h10) return 16'h1234;
    if (a == 8'h05) return 16'h0F0F;
    return {8'hA5, a};
  endfunction

  // Bus-level SRAM models (one per DUT)
  logic [15:0] mem0 [256];
  bit          wr0  [256];
  logic [15:0] mem1 [256];
  bit          wr1  [256];

  always @(posedge Clk) begin
    if (!sram_ce_n && !sram_we_n) begin
      mem0[sram_addr[7:0]] <= sram_dq_out;
      wr0[sram_addr[7:0]]  <= 1'b1;
    end
    if (!d1_ce_n && !d1_we_n) begin
      mem1[d1_addr[7:0]] <= d1_dq_out;
      wr1[d1_addr[7:0]]  <= 1'b1;
    end
  end

  assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ?
    (wr0[sram_addr[7:0]] ? mem0[sram_addr[7:0]] : init_val(sram_addr[7:0]))
    : 16'hDEAD;
  assign d1_dq_in = (!d1_ce_n && !d1_oe_n) ?
    (wr1[d1_addr[7:0]] ? mem1[d1_addr[7:0]] : init_val(d1_addr[7:0]))
    : 16'hDEAD;

  always @(negedge Clk) begin
    n_cmp = n_cmp + 1;
    if ((!sram_oe_n && !sram_we_n) || (!d1_oe_n && !d1_we_n)) begin
      n_bad = n_bad + 1;
      $display("FAIL oe_we_overlap: oe_n=%b we_n=%b d1 oe_n=%b we_n=%b want never both 0",
               sram_oe_n, sram_we_n, d1_oe_n, d1_we_n);
    end
  end

  // Transaction-level reference model
  logic [15:0] ref_mem [256];
  bit          m_last;
  logic [15:0] m_crd, m_lrd;

  task automatic model_reset();
    m_last = 1'b1;
    m_crd  = '0;
    m_lrd  = '0;
  endtask

  task automatic run_pair(
    input bit uc, input bit cw, input logic [7:0] ca, input logic [15:0] cd,
    input bit ul, input bit lw, input logic [7:0] la, input logic [15:0] ldd,
    input string tag);
    int kc, kl, ec, el, bad_tr;
    bit cf, w, in_seq, in_acc;
    logic [15:0] gc, gl;
    cf = uc && (!ul || m_last);
    ec = -1;
    el = -1;
    if (cf) begin
      ec = WC + 2;
      if (cw) ref_mem[ca] = cd; else m_crd = ref_mem[ca];
      if (ul) begin
        el = 2 * WC + 5;
        if (lw) ref_mem[la] = ldd; else m_lrd = ref_mem[la];
      end
      m_last = ul;
    end else if (ul) begin
      el = WC + 2;
      if (lw) ref_mem[la] = ldd; else m_lrd = ref_mem[la];
      if (uc) begin
        ec = 2 * WC + 5;
        if (cw) ref_mem[ca] = cd; else m_crd = ref_mem[ca];
      end
      m_last = !uc;
    end
    w = uc ? cw : lw;
    @(posedge Clk);
    #1;
    cpu_we = cw; cpu_addr = {12'h0, ca}; cpu_wdata = cd; cpu_req = uc;
    ld_we = lw;  ld_addr = {12'h0, la};  ld_wdata = ldd; ld_req = ul;
    kc = -1; kl = -1; bad_tr = 0; gc = '0; gl = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge Clk);
      if (uc ^ ul) begin
        in_seq = (k >= 1) && (k <= WC + 2);
        in_acc = (k >= 2) && (k <= WC + 1);
        if (sram_ce_n !== !in_seq) bad_tr++;
        if (busy !== in_seq) bad_tr++;
        if (sram_oe_n !== !(in_acc && !w)) bad_tr++;
        if (sram_we_n !== !(in_acc && w)) bad_tr++;
        if (sram_dq_oe !== (in_seq && w)) bad_tr++;
      end
      if (cpu_ack === 1'b1) begin
        if (kc < 0) begin kc = k; gc = cpu_rdata; end
        cpu_req = 1'b0;
      end
      if (ld_ack === 1'b1) begin
        if (kl < 0) begin kl = k; gl = ld_rdata; end
        ld_req = 1'b0;
      end
      if ((!uc || kc >= 0) && (!ul || kl >= 0)) break;
    end
    cpu_req = 1'b0;
    ld_req  = 1'b0;
    n_cmp++;
    if (kc != ec) begin
      n_bad++;
      $display("FAIL %s cpu_ack_cycle: got %0d want %0d", tag, kc, ec);
    end
    n_cmp++;
    if (kl != el) begin
      n_bad++;
      $display("FAIL %s ld_ack_cycle: got %0d want %0d", tag, kl, el);
    end
    if (uc && !cw) begin
      n_cmp++;
      if (gc !== m_crd) begin
        n_bad++;
        $display("FAIL %s cpu_rdata_at_ack: got %h want %h", tag, gc, m_crd);
      end
    end
    if (ul && !lw) begin
      n_cmp++;
      if (gl !== m_lrd) begin
        n_bad++;
        $display("FAIL %s ld_rdata_at_ack: got %h want %h", tag, gl, m_lrd);
      end
    end
    n_cmp++;
    if (cpu_rdata !== m_crd || ld_rdata !== m_lrd) begin
      n_bad++;
      $display("FAIL %s rdata_hold: got %h/%h want %h/%h",
               tag, cpu_rdata, ld_rdata, m_crd, m_lrd);
    end
    if (uc ^ ul) begin
      n_cmp++;
      if (bad_tr != 0) begin
        n_bad++;
        $display("FAIL %s strobe_trace: got %0d bad samples want 0", tag, bad_tr);
      end
    end
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    repeat (3) @(negedge Clk);
    n_cmp++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, busy, cpu_ack, ld_ack}
        !== 7'b1110000 || sram_addr !== '0 || sram_dq_out !== '0 ||
        cpu_rdata !== '0 || ld_rdata !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got ce/oe/we/oe/busy/acks=%b%b%b%b%b%b%b addr=%h want 1110000 addr=0",
               sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, busy, cpu_ack, ld_ack, sram_addr);
    end
    Reset_n = 1'b1;
    model_reset();
    repeat (4) @(negedge Clk);
    n_cmp++;
    if (busy !== 1'b0 || d1_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release_busy: got %b/%b want 0/0", busy, d1_busy);
    end
  endtask

  task automatic test_tie();
    run_pair(1, 0, 8'h10, 16'h0, 1, 0, 8'h05, 16'h0, "tie_after_reset");
  endtask

  task automatic test_cpu_read();
    run_pair(1, 0, 8'h10, 16'h0, 0, 0, 8'h0, 16'h0, "cpu_read");
    n_cmp++;
    if (cpu_rdata !== 16'h1234) begin
      n_bad++;
      $display("FAIL cpu_read_value: got %h want 1234", cpu_rdata);
    end
  endtask

  task automatic test_cpu_write();
    run_pair(1, 1, 8'h20, 16'hBEEF, 0, 0, 8'h0, 16'h0, "cpu_write");
    run_pair(1, 0, 8'h20, 16'h0, 0, 0, 8'h0, 16'h0, "cpu_readback");
    n_cmp++;
    if (cpu_rdata !== 16'hBEEF) begin
      n_bad++;
      $display("FAIL cpu_readback_value: got %h want BEEF", cpu_rdata);
    end
  endtask

  task automatic test_ld_read();
    run_pair(1, 0, 8'h10, 16'h0, 0, 0, 8'h0, 16'h0, "cpu_read_pre");
    run_pair(0, 0, 8'h0, 16'h0, 1, 0, 8'h05, 16'h0, "ld_read");
    n_cmp++;
    if (ld_rdata !== 16'h0F0F || cpu_rdata !== 16'h1234) begin
      n_bad++;
      $display("FAIL ld_read_isolation: got ld=%h cpu=%h want ld=0F0F cpu=1234",
               ld_rdata, cpu_rdata);
    end
  endtask

  task automatic test_alternate();
    int n;
    int at [3];
    bit got [3];
    bit p0;
    p0 = !m_last;
    n = 0;
    @(posedge Clk);
    #1;
    cpu_we = 0; cpu_addr = 20'h10; cpu_req = 1;
    ld_we = 0;  ld_addr = 20'h05;  ld_req = 1;
    for (int k = 0; k < 60; k++) begin
      @(negedge Clk);
      if (n < 3 && cpu_ack === 1'b1) begin got[n] = 0; at[n] = k; n++; end
      else if (n < 3 && ld_ack === 1'b1) begin got[n] = 1; at[n] = k; n++; end
      if (n == 3) break;
    end
    cpu_req = 0;
    ld_req = 0;
    m_crd = ref_mem[8'h10];
    m_lrd = ref_mem[8'h05];
    m_last = p0;
    n_cmp++;
    if (n != 3) begin
      n_bad++;
      $display("FAIL alternate_count: got %0d acks want 3", n);
    end
    for (int i = 0; i < n; i++) begin
      n_cmp++;
      if (got[i] != (p0 ^ i[0]) || at[i] != (WC + 2) + i * (WC + 3)) begin
        n_bad++;
        $display("FAIL alternate_grant%0d: got port %0d at %0d want port %0d at %0d",
                 i, got[i], at[i], p0 ^ i[0], (WC + 2) + i * (WC + 3));
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] atab [10];
    bit uc, ul;
    for (int i = 0; i < 8; i++) atab[i] = i[7:0];
    atab[8] = 8'h10;
    atab[9] = 8'h20;
    for (int i = 0; i < 30; i++) begin
      uc = 1'($urandom_range(0, 1));
      ul = 1'($urandom_range(0, 1));
      if (!uc && !ul) uc = 1'b1;
      run_pair(uc, 1'($urandom_range(0, 1)), atab[$urandom_range(0, 9)],
               16'($urandom), ul, 1'($urandom_range(0, 1)),
               atab[$urandom_range(0, 9)], 16'($urandom), "random");
    end
  endtask

  task automatic test_reset_mid_write();
    int acks;
    @(posedge Clk);
    #1;
    cpu_we = 1; cpu_addr = 20'hAA; cpu_wdata = 16'h5A5A; cpu_req = 1;
    repeat (3) @(negedge Clk);
    n_cmp++;
    if (sram_we_n !== 1'b0) begin
      n_bad++;
      $display("FAIL midwrite_in_access: got we_n=%b want 0", sram_we_n);
    end
    #1 Reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, busy, cpu_ack, ld_ack}
        !== 7'b1110000) begin
      n_bad++;
      $display("FAIL midwrite_async_drop: got %b%b%b%b%b%b%b want 1110000",
               sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, busy, cpu_ack, ld_ack);
    end
    cpu_req = 0;
    acks = 0;
    repeat (3) begin
      @(negedge Clk);
      if (cpu_ack === 1'b1 || ld_ack === 1'b1) acks++;
    end
    Reset_n = 1'b1;
    model_reset();
    repeat (4) begin
      @(negedge Clk);
      if (cpu_ack === 1'b1 || ld_ack === 1'b1) acks++;
    end
    n_cmp++;
    if (acks != 0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL midwrite_no_ack: got acks=%0d busy=%b want 0/0", acks, busy);
    end
    run_pair(1, 0, 8'h10, 16'h0, 0, 0, 8'h0, 16'h0, "after_reset_read");
  endtask

  task automatic test_wait1();
    int ka, oe_cnt, oe_first;
    @(posedge Clk);
    #1;
    d1_cpu_we = 0; d1_cpu_addr = 20'h10; d1_cpu_req = 1;
    ka = -1; oe_cnt = 0; oe_first = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge Clk);
      if (d1_oe_n === 1'b0) begin
        oe_cnt++;
        if (oe_first < 0) oe_first = k;
      end
      if (d1_cpu_ack === 1'b1) begin
        ka = k;
        d1_cpu_req = 0;
        break;
      end
    end
    d1_cpu_req = 0;
    n_cmp++;
    if (ka != 3 || oe_cnt != 1 || oe_first != 2) begin
      n_bad++;
      $display("FAIL wait1_timing: got ack=%0d oe_cnt=%0d oe_first=%0d want 3/1/2",
               ka, oe_cnt, oe_first);
    end
    n_cmp++;
    if (d1_cpu_rdata !== 16'h1234) begin
      n_bad++;
      $display("FAIL wait1_rdata: got %h want 1234", d1_cpu_rdata);
    end
  endtask

  initial begin
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ld_req = 0;  ld_we = 0;  ld_addr = '0;  ld_wdata = '0;
    d1_cpu_req = 0; d1_cpu_we = 0; d1_cpu_addr = '0; d1_cpu_wdata = '0;
    d1_ld_req = 0;  d1_ld_we = 0;  d1_ld_addr = '0;  d1_ld_wdata = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i[7:0]);
    model_reset();
    test_reset();
    test_tie();
    test_cpu_read();
    test_cpu_write();
    test_ld_read();
    test_alternate();
    test_random();
    test_reset_mid_write();
    test_wait1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
